pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Replaces the ad-hoc stop wires in the top-level CPU. Decides three things each cycle:
  - load-use stalls;
  - branch/jump wrong-path flushes;
  - whole-pipeline freezes while data memory is busy, with a hard timeout.
- Operand forwarding stays in the top level. This block only sequences pipeline-register enables and bubbles, and keeps stall/flush performance counters.

---
 rtl/pipe_hazard_if.sv | 48 ++++
 rtl/pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: hazard-control bundle between the CPU top level and
// pipe_hazard_ctrl.
//   Hazard inputs (master -> slave): ID source fields and read enables,
//   EX destination/write/load info, ex_jump, mem_busy.
//   Control outputs (slave -> master): pipeline-register stall/flush
//   enables, timeout_err, state_o, stall_cnt, flush_cnt.
// The master modport is the CPU (or bench) side; the slave modport is the
// hazard controller.
interface pipe_hazard_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_re;
  logic             id_rs2_re;
  logic [4:0]       ex_wr;
  logic             ex_reg_we;
  logic             ex_is_load;
  logic             ex_jump;
  logic             mem_busy;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             mem_wb_stall;
  logic             timeout_err;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_re, id_rs2_re, ex_wr, ex_reg_we,
           ex_is_load, ex_jump, mem_busy,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_stall, timeout_err, state_o, stall_cnt,
           flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_re, id_rs2_re, ex_wr, ex_reg_we,
           ex_is_load, ex_jump, mem_busy,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_stall, timeout_err, state_o, stall_cnt,
           flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush sequencer for the 5-stage pipeline.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   hz    : pipe_hazard_if slave port. Hazard inputs come in, and these go
//           out: pipeline-register stall/flush enables (combinational, zero
//           latency), the sticky timeout_err flag, the FSM state
//           (0 RUN, 1 MWAIT, 2 TIMEOUT) and the saturating stall/flush
//           counters.
// Priority each cycle: memory freeze, then EX redirect flush, then load-use
// bubble, then idle.
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input logic         clk,
  input logic         rst_n,
  pipe_hazard_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MWAIT   = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  // wait_cnt value that, with mem_busy still high, trips the timeout
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t           state_r;
  logic [7:0]       wait_cnt_r;
  logic             timeout_err_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic freeze_s;
  logic rs1_hit_s;
  logic rs2_hit_s;
  logic load_use_s;
  logic jump_flush_s;
  logic pc_stall_s;
  logic if_id_stall_s;
  logic if_id_flush_s;
  logic id_ex_stall_s;
  logic id_ex_flush_s;
  logic ex_mem_stall_s;
  logic mem_wb_stall_s;

  // Saturating increment: the counter sticks at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Hazard decode and prioritised stall/flush selection
  always_comb begin
    freeze_s   = hz.mem_busy | (state_r == ST_TIMEOUT);
    rs1_hit_s  = hz.id_rs1_re & (hz.id_rs1 == hz.ex_wr);
    rs2_hit_s  = hz.id_rs2_re & (hz.id_rs2 == hz.ex_wr);
    load_use_s = hz.ex_is_load & hz.ex_reg_we & (hz.ex_wr != 5'd0) &
                 (rs1_hit_s | rs2_hit_s);

    jump_flush_s   = 1'b0;
    pc_stall_s     = 1'b0;
    if_id_stall_s  = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_stall_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_stall_s = 1'b0;
    mem_wb_stall_s = 1'b0;

    // Reset gating lets every control output drop the moment rst_n falls,
    // even while mem_busy or ex_jump are still high.
    if (!rst_n) begin
      jump_flush_s = 1'b0;
    end else if (freeze_s) begin
      // EX/ID contents are held, so any jump or load-use is re-seen later
      pc_stall_s     = 1'b1;
      if_id_stall_s  = 1'b1;
      id_ex_stall_s  = 1'b1;
      ex_mem_stall_s = 1'b1;
      mem_wb_stall_s = 1'b1;
    end else if (hz.ex_jump) begin
      // The ID instruction is on the wrong path, so its load-use is moot
      jump_flush_s  = 1'b1;
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else if (load_use_s) begin
      // One bubble; next cycle the load sits in MEM and forwarding covers it
      pc_stall_s    = 1'b1;
      if_id_stall_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else begin
      jump_flush_s = 1'b0;
    end
  end

  // Memory-wait FSM with timeout; TIMEOUT is absorbing until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= 8'd0;
      timeout_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (hz.mem_busy) begin
            state_r    <= ST_MWAIT;
            wait_cnt_r <= 8'd1;
          end else begin
            state_r    <= ST_RUN;
            wait_cnt_r <= 8'd0;
          end
        end
        ST_MWAIT: begin
          if (!hz.mem_busy) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= 8'd0;
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r       <= ST_TIMEOUT;
            timeout_err_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_TIMEOUT: begin
          state_r       <= ST_TIMEOUT;
          timeout_err_r <= 1'b1;
        end
        default: begin
          state_r    <= ST_RUN;
          wait_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  // Saturating stall/flush performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (pc_stall_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (jump_flush_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
    end
  end

  assign hz.pc_stall     = pc_stall_s;
  assign hz.if_id_stall  = if_id_stall_s;
  assign hz.if_id_flush  = if_id_flush_s;
  assign hz.id_ex_stall  = id_ex_stall_s;
  assign hz.id_ex_flush  = id_ex_flush_s;
  assign hz.ex_mem_stall = ex_mem_stall_s;
  assign hz.mem_wb_stall = mem_wb_stall_s;
  assign hz.timeout_err  = timeout_err_r;
  assign hz.state_o      = state_r;
  assign hz.stall_cnt    = stall_cnt_r;
  assign hz.flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl.
// Instance a uses MAX_WAIT = 16, CNT_W = 32; instance b uses CNT_W = 4 for
// counter saturation. Inputs change on the falling edge and outputs are
// sampled 1 ns later, so counters reflect all rising edges seen so far.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  pipe_hazard_if #(.CNT_W(32)) ha ();
  pipe_hazard_if #(.CNT_W(4))  hb ();

  pipe_hazard_ctrl #(.MAX_WAIT(16), .CNT_W(32)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (ha.slave)
  );

  pipe_hazard_ctrl #(.MAX_WAIT(16), .CNT_W(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_a();
    ha.id_rs1 = 5'd0; ha.id_rs2 = 5'd0; ha.id_rs1_re = 1'b0;
    ha.id_rs2_re = 1'b0; ha.ex_wr = 5'd0; ha.ex_reg_we = 1'b0;
    ha.ex_is_load = 1'b0; ha.ex_jump = 1'b0; ha.mem_busy = 1'b0;
  endtask

  task automatic clear_b();
    hb.id_rs1 = 5'd0; hb.id_rs2 = 5'd0; hb.id_rs1_re = 1'b0;
    hb.id_rs2_re = 1'b0; hb.ex_wr = 5'd0; hb.ex_reg_we = 1'b0;
    hb.ex_is_load = 1'b0; hb.ex_jump = 1'b0; hb.mem_busy = 1'b0;
  endtask

  // Pack the seven control outputs of instance a:
  // {pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem, mem_wb}
  function automatic logic [31:0] ctl_a();
    return {25'd0, ha.pc_stall, ha.if_id_stall, ha.if_id_flush,
            ha.id_ex_stall, ha.id_ex_flush, ha.ex_mem_stall, ha.mem_wb_stall};
  endfunction

  task automatic set_load_a(input logic [4:0] wr);
    ha.ex_is_load = 1'b1; ha.ex_reg_we = 1'b1; ha.ex_wr = wr;
  endtask

  // Hard time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    clear_a();
    clear_b();

    // Reset: outputs stay 0 even with busy/jump asserted
    ha.mem_busy = 1'b1;
    ha.ex_jump  = 1'b1;
    #1;
    check_eq("reset_ctl", ctl_a(), 32'h00);
    check_eq("reset_state", {30'd0, ha.state_o}, 32'd0);
    check_eq("reset_stall_cnt", ha.stall_cnt, 32'd0);
    check_eq("reset_flush_cnt", ha.flush_cnt, 32'd0);
    check_eq("reset_timeout", {31'd0, ha.timeout_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    clear_a();
    rst_n = 1'b1;
    @(negedge clk);

    // Load-use on rs1: pc, if_id_stall, id_ex_flush for one cycle
    set_load_a(5'd5);
    ha.id_rs1 = 5'd5; ha.id_rs1_re = 1'b1;
    #1;
    check_eq("lu_rs1_ctl", ctl_a(), 32'b1100100);
    @(negedge clk);
    clear_a();
    #1;
    check_eq("lu_rs1_cnt", ha.stall_cnt, 32'd1);
    check_eq("lu_rs1_release", ctl_a(), 32'h00);

    // ex_wr = 0 never stalls
    set_load_a(5'd0);
    ha.id_rs1 = 5'd0; ha.id_rs1_re = 1'b1;
    #1;
    check_eq("lu_x0_ctl", ctl_a(), 32'h00);
    @(negedge clk);

    // Non-writing load never stalls
    set_load_a(5'd9);
    ha.ex_reg_we = 1'b0;
    ha.id_rs1 = 5'd9; ha.id_rs1_re = 1'b1;
    #1;
    check_eq("lu_nowe_ctl", ctl_a(), 32'h00);
    @(negedge clk);
    clear_a();

    // Load-use on rs2, rs1 not read
    set_load_a(5'd7);
    ha.id_rs2 = 5'd7; ha.id_rs2_re = 1'b1;
    ha.id_rs1 = 5'd7; ha.id_rs1_re = 1'b0;
    #1;
    check_eq("lu_rs2_ctl", ctl_a(), 32'b1100100);
    @(negedge clk);
    clear_a();
    #1;
    check_eq("lu_rs2_cnt", ha.stall_cnt, 32'd2);

    // Jump with load-use also true: flush wins, no stall
    set_load_a(5'd5);
    ha.id_rs1 = 5'd5; ha.id_rs1_re = 1'b1;
    ha.ex_jump = 1'b1;
    #1;
    check_eq("jump_ctl", ctl_a(), 32'b0010100);
    @(negedge clk);
    clear_a();
    #1;
    check_eq("jump_flush_cnt", ha.flush_cnt, 32'd1);
    check_eq("jump_stall_cnt", ha.stall_cnt, 32'd2);

    // Memory wait of 3 cycles
    for (int i = 0; i < 3; i++) begin
      ha.mem_busy = 1'b1;
      #1;
      check_eq($sformatf("mwait_ctl_%0d", i), ctl_a(), 32'b1101011);
      check_eq($sformatf("mwait_state_%0d", i), {30'd0, ha.state_o},
               (i == 0) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
    ha.mem_busy = 1'b0;
    #1;
    check_eq("mwait_end_ctl", ctl_a(), 32'h00);
    check_eq("mwait_end_state", {30'd0, ha.state_o}, 32'd1);
    check_eq("mwait_stall_cnt", ha.stall_cnt, 32'd5);
    @(negedge clk);
    #1;
    check_eq("mwait_run_state", {30'd0, ha.state_o}, 32'd0);
    check_eq("mwait_timeout", {31'd0, ha.timeout_err}, 32'd0);

    // Freeze over jump: no flush while frozen, flush when released
    for (int i = 0; i < 2; i++) begin
      ha.mem_busy = 1'b1;
      ha.ex_jump  = 1'b1;
      #1;
      check_eq($sformatf("fz_jump_ctl_%0d", i), ctl_a(), 32'b1101011);
      @(negedge clk);
    end
    ha.mem_busy = 1'b0;
    #1;
    check_eq("fz_jump_release_ctl", ctl_a(), 32'b0010100);
    @(negedge clk);
    clear_a();
    #1;
    check_eq("fz_jump_flush_cnt", ha.flush_cnt, 32'd2);
    check_eq("fz_jump_stall_cnt", ha.stall_cnt, 32'd7);
    check_eq("fz_jump_state", {30'd0, ha.state_o}, 32'd0);

    // Timeout after 16 consecutive busy cycles
    for (int i = 0; i < 16; i++) begin
      ha.mem_busy = 1'b1;
      #1;
      if (i == 15) begin
        check_eq("to_pre_state", {30'd0, ha.state_o}, 32'd1);
        check_eq("to_pre_err", {31'd0, ha.timeout_err}, 32'd0);
      end
      @(negedge clk);
    end
    ha.mem_busy = 1'b0;
    ha.ex_jump  = 1'b1;
    #1;
    check_eq("to_state", {30'd0, ha.state_o}, 32'd2);
    check_eq("to_err", {31'd0, ha.timeout_err}, 32'd1);
    check_eq("to_hold_ctl", ctl_a(), 32'b1101011);
    check_eq("to_stall_cnt", ha.stall_cnt, 32'd23);
    @(negedge clk);
    #1;
    check_eq("to_stall_cnt2", ha.stall_cnt, 32'd24);
    check_eq("to_flush_cnt", ha.flush_cnt, 32'd2);
    check_eq("to_absorb_state", {30'd0, ha.state_o}, 32'd2);

    // Asynchronous reset pulse mid-cycle
    rst_n = 1'b0;
    #1;
    check_eq("areset_ctl", ctl_a(), 32'h00);
    check_eq("areset_state", {30'd0, ha.state_o}, 32'd0);
    check_eq("areset_stall_cnt", ha.stall_cnt, 32'd0);
    check_eq("areset_flush_cnt", ha.flush_cnt, 32'd0);
    check_eq("areset_err", {31'd0, ha.timeout_err}, 32'd0);
    @(negedge clk);
    clear_a();
    rst_n = 1'b1;
    @(negedge clk);

    // Saturation on the 4-bit instance: permanent load-use for 20 cycles
    hb.ex_is_load = 1'b1; hb.ex_reg_we = 1'b1; hb.ex_wr = 5'd3;
    hb.id_rs1 = 5'd3; hb.id_rs1_re = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      #1;
      if (i == 10) begin
        check_eq("sat_mid", {28'd0, hb.stall_cnt}, 32'd10);
      end
    end
    check_eq("sat_end", {28'd0, hb.stall_cnt}, 32'd15);
    check_eq("sat_pc_stall", {31'd0, hb.pc_stall}, 32'd1);
    clear_b();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
